// File: rtl/inst_fetcher.sv
// inst_fetcher: single-outstanding instruction fetch FSM feeding a small instruction queue
module inst_fetcher #(
   parameter int          QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear_up,
   input  logic [31:0] rob_new_pc,
   input  logic        dec_redirect,
   input  logic [31:0] dec_new_pc,
   output logic        should_fetch,
   output logic [31:0] pc,
   input  logic        inst_ready,
   input  logic [31:0] inst,
   input  logic        dec_ready,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
   typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;
   state_t state, state_nxt;
   logic [31:0] fetch_pc, fetch_nxt, pc_nxt, target;
   logic should_fetch_nxt, redirect, push, pop;
   logic [63:0] mem [QUEUE_DEPTH];
   logic [AW-1:0] head, tail;
   logic [CW-1:0] count;
   assign redirect = rob_clear_up | dec_redirect;
   assign target = rob_clear_up ? rob_new_pc : dec_new_pc;
   assign inst_valid = count != '0;
   assign pop = inst_valid & dec_ready;
   assign inst_out = inst_valid ? mem[head][63:32] : '0;
   assign inst_pc = inst_valid ? mem[head][31:0] : '0;
   always_comb begin
      state_nxt = state;
      fetch_nxt = redirect ? target : fetch_pc;
      should_fetch_nxt = should_fetch;
      pc_nxt = pc;
      push = 1'b0;
      case (state)
         IDLE: if (!redirect && count < DEPTH_C) begin
            state_nxt = FETCH;
            should_fetch_nxt = 1'b1;
            pc_nxt = fetch_pc;
         end
         FETCH: if (inst_ready) begin
            state_nxt = IDLE;
            should_fetch_nxt = 1'b0;
            push = !redirect;
            fetch_nxt = redirect ? target : pc + 32'd4;
         end else if (redirect) begin
            state_nxt = DROP;
         end
         DROP: if (inst_ready) begin
            state_nxt = IDLE;
            should_fetch_nxt = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         fetch_pc <= RESET_PC;
         should_fetch <= 1'b0;
         pc <= RESET_PC;
         head <= '0;
         tail <= '0;
         count <= '0;
      end else if (rdy_in) begin
         state <= state_nxt;
         fetch_pc <= fetch_nxt;
         should_fetch <= should_fetch_nxt;
         pc <= pc_nxt;
         // a redirect flushes the queue and overrides any concurrent push/pop
         if (redirect) begin
            head <= '0;
            tail <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && push) mem[tail] <= {inst, pc};
   end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed and randomized checks of inst_fetcher against a queue-based reference model
module tb_inst_fetcher;
   localparam int          QD = 4;
   localparam logic [31:0] RPC = 32'h0;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rob_clear_up, dec_redirect, inst_ready, dec_ready;
   logic [31:0] rob_new_pc, dec_new_pc, inst;
   logic        should_fetch, inst_valid;
   logic [31:0] pc, inst_out, inst_pc;
   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] m_q[$];
   logic        m_sf, m_drop;
   logic [31:0] m_pc, m_fpc;

   inst_fetcher #(.QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .rob_clear_up(rob_clear_up), .rob_new_pc(rob_new_pc),
      .dec_redirect(dec_redirect), .dec_new_pc(dec_new_pc),
      .should_fetch(should_fetch), .pc(pc),
      .inst_ready(inst_ready), .inst(inst), .dec_ready(dec_ready),
      .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference: one outstanding request, a "drop" flag for poisoned responses, plain queue
   task automatic model_step();
      logic        redir, push, pop;
      logic [31:0] tgt;
      int          sz;
      if (rst_in) begin
         m_q.delete();
         m_sf = 1'b0;
         m_drop = 1'b0;
         m_pc = RPC;
         m_fpc = RPC;
      end else if (rdy_in) begin
         redir = rob_clear_up | dec_redirect;
         tgt = rob_clear_up ? rob_new_pc : dec_new_pc;
         sz = m_q.size();
         pop = (sz > 0) && dec_ready;
         push = 1'b0;
         if (!m_sf) begin
            if (!redir && sz < QD) begin
               m_sf = 1'b1;
               m_pc = m_fpc;
            end
         end else if (inst_ready) begin
            push = !m_drop && !redir;
            if (push) m_fpc = m_pc + 32'd4;
            m_sf = 1'b0;
            m_drop = 1'b0;
         end else if (redir) begin
            m_drop = 1'b1;
         end
         if (redir) begin
            m_fpc = tgt;
            m_q.delete();
         end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({inst, m_pc});
         end
      end
   endtask

   task automatic tick();
      logic [63:0] h;
      @(posedge clk_in);
      model_step();
      #1;
      h = (m_q.size() > 0) ? m_q[0] : 64'h0;
      chk("should_fetch", {31'b0, should_fetch}, {31'b0, m_sf});
      chk("pc", pc, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() > 0});
      chk("inst_out", inst_out, h[63:32]);
      chk("inst_pc", inst_pc, h[31:0]);
   endtask

   task automatic set_idle();
      rst_in = 1'b0; rdy_in = 1'b1; rob_clear_up = 1'b0; dec_redirect = 1'b0;
      inst_ready = 1'b0; dec_ready = 1'b0; rob_new_pc = '0; dec_new_pc = '0; inst = '0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && !should_fetch; i++) tick();
      chk("req_seen", {31'b0, should_fetch}, 32'd1);
   endtask

   task automatic fetch_one(input logic [31:0] w, input int lat);
      wait_req();
      repeat (lat) tick();
      inst_ready = 1'b1;
      inst = w;
      tick();
      inst_ready = 1'b0;
   endtask

   initial begin
      set_idle();
      m_q.delete(); m_sf = 1'b0; m_drop = 1'b0; m_pc = RPC; m_fpc = RPC;
      rst_in = 1'b1;
      tick();
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_out", inst_out, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      rst_in = 1'b0;
      // first fetch answered three cycles after the request
      fetch_one(32'h00000013, 2);
      chk("first_valid", {31'b0, inst_valid}, 32'd1);
      chk("first_out", inst_out, 32'h00000013);
      chk("first_inst_pc", inst_pc, 32'h0);
      wait_req();
      chk("second_pc", pc, 32'h4);
      // fill the queue with the decoder stalled
      for (int i = 0; i < 3; i++) fetch_one($urandom, 1);
      repeat (3) tick();
      chk("full_no_fetch", {31'b0, should_fetch}, 32'd0);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      wait_req();
      chk("after_pop_pc", pc, 32'h10);
      // ROB flush while a request is outstanding
      rob_clear_up = 1'b1; rob_new_pc = 32'h100;
      tick();
      rob_clear_up = 1'b0;
      chk("flush_empty", {31'b0, inst_valid}, 32'd0);
      tick();
      inst_ready = 1'b1; inst = $urandom;
      tick();
      inst_ready = 1'b0;
      chk("drop_no_push", {31'b0, inst_valid}, 32'd0);
      wait_req();
      chk("flush_pc", pc, 32'h100);
      // simultaneous redirects: ROB target wins
      fetch_one($urandom, 0);
      rob_clear_up = 1'b1; rob_new_pc = 32'h200; dec_redirect = 1'b1; dec_new_pc = 32'h300;
      tick();
      rob_clear_up = 1'b0; dec_redirect = 1'b0;
      wait_req();
      chk("prio_pc", pc, 32'h200);
      // fetch_pc wrap
      fetch_one($urandom, 0);
      rob_clear_up = 1'b1; rob_new_pc = 32'hFFFFFFFC;
      tick();
      rob_clear_up = 1'b0;
      fetch_one(32'hDEADBEEF, 1);
      chk("wrap_head_pc", inst_pc, 32'hFFFFFFFC);
      wait_req();
      chk("wrap_pc", pc, 32'h0);
      // freeze mid-FETCH
      rdy_in = 1'b0; dec_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         inst_ready = (i % 2) == 0;
         inst = $urandom;
         tick();
         chk("stall_pc", pc, 32'h0);
         chk("stall_sf", {31'b0, should_fetch}, 32'd1);
         chk("stall_head", inst_pc, 32'hFFFFFFFC);
      end
      set_idle();
      fetch_one($urandom, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_in = ($urandom % 200) == 0;
         rdy_in = ($urandom % 8) != 0;
         rob_clear_up = ($urandom % 16) == 0;
         dec_redirect = ($urandom % 12) == 0;
         rob_new_pc = $urandom & 32'hFFFFFFFC;
         dec_new_pc = $urandom & 32'hFFFFFFFC;
         inst_ready = m_sf && (($urandom % 3) == 0);
         inst = $urandom;
         dec_ready = $urandom % 2;
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
